ysyx_25040129_burst_mem: RTL

YSYX_25040129_BURST_MEM -- requirements
Module: ysyx_25040129_burst_mem

---
 rtl/ysyx_25040129_burst_mem_pkg.sv | 20 ++
 rtl/ysyx_25040129_burst_addr_gen.sv | 34 +++
 rtl/ysyx_25040129_burst_mem.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_burst_mem_pkg.sv
// Shared constants for the burst-read memory: burst types, response codes, FSM states.
package ysyx_25040129_burst_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        BURST = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_25040129_burst_addr_gen.sv
// Combinational beat word-address generator for FIXED/INCR/WRAP bursts,
// flagging WRAP lengths outside {2,4,8,16} beats and the reserved burst type.
module ysyx_25040129_burst_addr_gen
    import ysyx_25040129_burst_mem_pkg::*;
(
    input  logic [29:0] start_word,
    input  logic [7:0]  beat,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [29:0] beat_word,
    output logic        illegal
);

    logic [29:0] wrap_mask;
    logic [29:0] incr_word;

    always_comb begin
        wrap_mask = {22'd0, len};
        incr_word = start_word + {22'd0, beat};
        beat_word = start_word;
        illegal   = 1'b0;
        case (burst)
            BURST_FIXED: beat_word = start_word;
            BURST_INCR:  beat_word = incr_word;
            BURST_WRAP: begin
                // Legal wrap lengths make len a low-bit mask of the aligned window.
                beat_word = (start_word & ~wrap_mask) | (incr_word & wrap_mask);
                illegal   = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_burst_mem.sv
// Burst-read word memory with a preload port; optional random first-beat delay
// enabled by defining YSYX_25040129_BURST_MEM_DELAY_EN.
module ysyx_25040129_burst_mem
    import ysyx_25040129_burst_mem_pkg::*;
#(
    parameter int          MEM_DIG = 10,
    parameter logic [31:0] BASE    = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        araddr,
    input  logic               arvalid,
    output logic               arready,
    input  logic [7:0]         arlen,
    input  logic [1:0]         arburst,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rvalid,
    input  logic               rready,
    output logic               rlast,
    input  logic               ld_we,
    input  logic [MEM_DIG-1:0] ld_addr,
    input  logic [31:0]        ld_data
);

    localparam logic [29:0] BASE_WORD = BASE[31:2];
    localparam logic [29:0] DEPTH_W   = 30'(1) << MEM_DIG;

    logic [31:0] mem [0:(1<<MEM_DIG)-1];

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d, beat_q, beat_d;
    logic [1:0]  burst_q, burst_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic        load_beat;

    logic [29:0]        gen_start, gen_word, word_off;
    logic [7:0]         gen_beat, gen_len;
    logic [1:0]         gen_burst;
    logic               gen_illegal, in_range;
    logic [MEM_DIG-1:0] rd_idx;
    logic               unused_lsb;

    assign unused_lsb = ^araddr[1:0];

`ifdef YSYX_25040129_BURST_MEM_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  cnt_q, cnt_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    // In IDLE the generator sees the incoming request so beat 0 is read at the handshake edge.
    always_comb begin
        if (state_q == IDLE) begin
            gen_start = araddr[31:2];
            gen_len   = arlen;
            gen_burst = arburst;
            gen_beat  = '0;
        end else begin
            gen_start = addr_q;
            gen_len   = len_q;
            gen_burst = burst_q;
            gen_beat  = (state_q == BURST) ? beat_q + 8'd1 : beat_q;
        end
    end

    ysyx_25040129_burst_addr_gen u_addr_gen (
        .start_word (gen_start),
        .beat       (gen_beat),
        .len        (gen_len),
        .burst      (gen_burst),
        .beat_word  (gen_word),
        .illegal    (gen_illegal)
    );

    assign word_off = gen_word - BASE_WORD;
    assign in_range = word_off < DEPTH_W;
    assign rd_idx   = word_off[MEM_DIG-1:0];

    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        load_beat = 1'b0;
`ifdef YSYX_25040129_BURST_MEM_DELAY_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (arvalid) begin
                    addr_d  = araddr[31:2];
                    len_d   = arlen;
                    burst_d = arburst;
                    beat_d  = '0;
`ifdef YSYX_25040129_BURST_MEM_DELAY_EN
                    if (lfsr_q[2:0] != 3'd0) begin
                        state_d = DELAY;
                        cnt_d   = lfsr_q[2:0];
                    end else begin
                        state_d   = BURST;
                        load_beat = 1'b1;
                    end
`else
                    state_d   = BURST;
                    load_beat = 1'b1;
`endif
                end
            end
            DELAY: begin
`ifdef YSYX_25040129_BURST_MEM_DELAY_EN
                if (cnt_q == 3'd1) begin
                    state_d   = BURST;
                    load_beat = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
`else
                state_d = IDLE;
`endif
            end
            BURST: begin
                if (rready) begin
                    if (beat_q == len_q) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        beat_d    = beat_q + 8'd1;
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_beat) begin
            rvalid_d = 1'b1;
            rlast_d  = (gen_beat == gen_len);
            if (gen_illegal) begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
            end else if (!in_range) begin
                rresp_d = RESP_DECERR;
                rdata_d = '0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    assign arready = (state_q == IDLE);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;

endmodule
